// File: rtl/ysyx_22041211_alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the EXU (req 0)
// and the branch/AGU side path (req 1), with one transaction in flight.
module ysyx_22041211_alu_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int OP_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [2*DATA_LEN-1:0] req_src1_i,
  input  logic [2*DATA_LEN-1:0] req_src2_i,
  input  logic [2*OP_W-1:0]     req_op_i,
  output logic [1:0]            resp_valid_o,
  input  logic [1:0]            resp_ready_i,
  output logic [DATA_LEN-1:0]   resp_result_o,
  output logic                  resp_zero_o,
  output logic                  resp_less_o,
  output logic                  resp_id_o,
  output logic [DATA_LEN-1:0]   alu_src1_o,
  output logic [DATA_LEN-1:0]   alu_src2_o,
  output logic [OP_W-1:0]       alu_op_o,
  input  logic [DATA_LEN-1:0]   alu_result_i,
  input  logic                  alu_zero_i,
  input  logic                  alu_less_i,
  output logic [1:0]            dbg_state_o
);

  // Handshake rule (both request and response sides): a transfer happens on a
  // rising clk edge where valid and ready are both high; a requester keeps its
  // src/op stable while valid is high and the transfer has not yet happened.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_prio;
  logic                r_id;
  logic [1:0]          w_grant;
  logic                w_gnt_id;
  logic                w_req_fire;
  logic                w_resp_fire;
  logic [DATA_LEN-1:0] r_alu_src1;
  logic [DATA_LEN-1:0] r_alu_src2;
  logic [OP_W-1:0]     r_alu_op;
  logic [DATA_LEN-1:0] r_resp_result;
  logic                r_resp_zero;
  logic                r_resp_less;

  // Grant is only offered in IDLE; on contention the prio side wins.
  always_comb begin
    w_grant = 2'b00;
    if (rst_n && (r_state == S_IDLE)) begin
      case (req_valid_i)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_gnt_id    = w_grant[1];
  assign w_req_fire  = |w_grant;
  assign w_resp_fire = (r_state == S_RESP) && resp_ready_i[r_id];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_fire) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_resp_fire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_fire) begin
        r_id   <= w_gnt_id;
        r_prio <= ~w_gnt_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_src1    <= '0;
      r_alu_src2    <= '0;
      r_alu_op      <= '0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_less   <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_alu_src1 <= w_gnt_id ? req_src1_i[DATA_LEN +: DATA_LEN] : req_src1_i[0 +: DATA_LEN];
        r_alu_src2 <= w_gnt_id ? req_src2_i[DATA_LEN +: DATA_LEN] : req_src2_i[0 +: DATA_LEN];
        r_alu_op   <= w_gnt_id ? req_op_i[OP_W +: OP_W] : req_op_i[0 +: OP_W];
      end
      if (r_state == S_EXEC) begin
        r_resp_result <= alu_result_i;
        r_resp_zero   <= alu_zero_i;
        r_resp_less   <= alu_less_i;
      end
    end
  end

  assign req_ready_o   = w_grant;
  assign resp_valid_o  = (r_state == S_RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign resp_result_o = r_resp_result;
  assign resp_zero_o   = r_resp_zero;
  assign resp_less_o   = r_resp_less;
  assign resp_id_o     = r_id;
  assign alu_src1_o    = r_alu_src1;
  assign alu_src2_o    = r_alu_src2;
  assign alu_op_o      = r_alu_op;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_ysyx_22041211_alu_arbiter.sv
// Bench for the shared-ALU arbiter: directed scenarios plus randomized traffic,
// with a behavioural ALU and round-robin reference model.
module tb_ysyx_22041211_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_src1_i;
  logic [63:0] req_src2_i;
  logic [7:0]  req_op_i;
  logic [1:0]  resp_valid_o;
  logic [1:0]  resp_ready_i;
  logic [31:0] resp_result_o;
  logic        resp_zero_o;
  logic        resp_less_o;
  logic        resp_id_o;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        alu_less_i;
  logic [1:0]  dbg_state_o;

  // requester-side stimulus state
  logic [1:0]  t_v;
  logic [31:0] t_s1 [2];
  logic [31:0] t_s2 [2];
  logic [3:0]  t_op [2];

  // reference model state
  bit          m_prio;
  logic [31:0] last_s1;
  logic [3:0]  last_op;

  int n_checks;
  int n_errors;

  assign req_valid_i = t_v;
  assign req_src1_i  = {t_s1[1], t_s1[0]};
  assign req_src2_i  = {t_s2[1], t_s2[0]};
  assign req_op_i    = {t_op[1], t_op[0]};

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'b0, a < b};
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic less_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == OP_SLTU) ? (a < b) : ($signed(a) < $signed(b));
  endfunction

  function automatic logic [1:0] oh(input int i);
    return (i != 0) ? 2'b10 : 2'b01;
  endfunction

  // shared ALU the arbiter drives
  assign alu_result_i = alu_fn(alu_op_o, alu_src1_o, alu_src2_o);
  assign alu_zero_i   = (alu_src1_o == alu_src2_o);
  assign alu_less_i   = less_fn(alu_op_o, alu_src1_o, alu_src2_o);

  ysyx_22041211_alu_arbiter #(.DATA_LEN(32), .OP_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_src1_i    (req_src1_i),
    .req_src2_i    (req_src2_i),
    .req_op_i      (req_op_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_result_o (resp_result_o),
    .resp_zero_o   (resp_zero_o),
    .resp_less_o   (resp_less_o),
    .resp_id_o     (resp_id_o),
    .alu_src1_o    (alu_src1_o),
    .alu_src2_o    (alu_src2_o),
    .alu_op_o      (alu_op_o),
    .alu_result_i  (alu_result_i),
    .alu_zero_i    (alu_zero_i),
    .alu_less_i    (alu_less_i),
    .dbg_state_o   (dbg_state_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  {30'b0, req_ready_o},  32'h0);
    chk({tag, "_resp_valid"}, {30'b0, resp_valid_o}, 32'h0);
    chk({tag, "_resp_result"}, resp_result_o, 32'h0);
    chk({tag, "_resp_flags"}, {29'b0, resp_zero_o, resp_less_o, resp_id_o}, 32'h0);
    chk({tag, "_alu_src1"}, alu_src1_o, 32'h0);
    chk({tag, "_alu_src2"}, alu_src2_o, 32'h0);
    chk({tag, "_alu_op"},   {28'b0, alu_op_o}, 32'h0);
  endtask

  task automatic rand_req(input int n);
    t_s1[n] = $urandom;
    t_s2[n] = ($urandom_range(0, 3) == 0) ? t_s1[n] : $urandom;
    t_op[n] = 4'($urandom_range(0, 15));
  endtask

  task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    t_op[n] = op;
    t_s1[n] = a;
    t_s2[n] = b;
  endtask

  // One full transaction: grant check, EXEC, RESP with optional backpressure.
  task automatic do_one(input int dly, input bit wrong, input bit other_on);
    int g;
    logic [31:0] s1, s2, er;
    logic [3:0]  op;
    logic        ez, el;
    #1;
    g = (t_v == 2'b11) ? int'(m_prio) : (t_v[1] ? 1 : 0);
    chk("grant", {30'b0, req_ready_o}, {30'b0, oh(g)});
    s1 = t_s1[g];
    s2 = t_s2[g];
    op = t_op[g];
    er = alu_fn(op, s1, s2);
    ez = (s1 == s2);
    el = less_fn(op, s1, s2);
    m_prio  = (g == 0);
    last_s1 = s1;
    last_op = op;
    resp_ready_i = 2'b00;
    @(posedge clk); #1;
    t_v[g] = 1'b0;
    if (other_on) t_v[1-g] = 1'b1;
    chk("exec_req_ready",  {30'b0, req_ready_o},  32'h0);
    chk("exec_resp_valid", {30'b0, resp_valid_o}, 32'h0);
    chk("alu_src1", alu_src1_o, s1);
    chk("alu_src2", alu_src2_o, s2);
    chk("alu_op",   {28'b0, alu_op_o}, {28'b0, op});
    @(posedge clk); #1;
    chk("resp_valid",  {30'b0, resp_valid_o}, {30'b0, oh(g)});
    chk("resp_result", resp_result_o, er);
    chk("resp_zero",   {31'b0, resp_zero_o}, {31'b0, ez});
    chk("resp_less",   {31'b0, resp_less_o}, {31'b0, el});
    chk("resp_id",     {31'b0, resp_id_o},   32'(g));
    for (int d = 0; d < dly; d++) begin
      resp_ready_i = wrong ? oh(1 - g) : 2'b00;
      @(posedge clk); #1;
      chk("hold_resp_valid",  {30'b0, resp_valid_o}, {30'b0, oh(g)});
      chk("hold_resp_result", resp_result_o, er);
      chk("hold_req_ready",   {30'b0, req_ready_o}, 32'h0);
    end
    resp_ready_i = oh(g);
    @(posedge clk); #1;
    chk("resp_done", {30'b0, resp_valid_o}, 32'h0);
    resp_ready_i = 2'b00;
  endtask

  // Accept a request, then reset in EXEC (where=1) or RESP (where=2).
  task automatic txn_then_reset(input int where);
    int g;
    #1;
    g = (t_v == 2'b11) ? int'(m_prio) : (t_v[1] ? 1 : 0);
    chk("rst_pre_grant", {30'b0, req_ready_o}, {30'b0, oh(g)});
    resp_ready_i = 2'b00;
    @(posedge clk); #1;
    if (where == 2) begin
      @(posedge clk); #1;
      chk("rst_pre_resp_valid", {30'b0, resp_valid_o}, {30'b0, oh(g)});
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero((where == 2) ? "rst_in_resp" : "rst_in_exec");
    rst_n  = 1'b1;
    m_prio = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_prio   = 1'b0;
    last_s1  = '0;
    last_op  = '0;
    resp_ready_i = 2'b00;
    t_v = 2'b00;
    for (int i = 0; i < 2; i++) set_req(i, OP_ADD, 32'h0, 32'h0);

    // Reset with both requesters already valid (contention from reset)
    rst_n = 1'b0;
    set_req(0, OP_SUB, 32'd3, 32'd3);
    set_req(1, OP_SLTU, 32'd1, 32'd2);
    t_v = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Contention: req0 first, then alternation over four transactions
    do_one(0, 1'b0, 1'b0);
    rand_req(0); t_v[0] = 1'b1;
    do_one(0, 1'b0, 1'b0);
    rand_req(1); t_v[1] = 1'b1;
    do_one(0, 1'b0, 1'b0);
    do_one(0, 1'b0, 1'b0);

    // No request: grant stays off and ALU operands hold
    repeat (2) @(posedge clk);
    #1;
    chk("idle_req_ready", {30'b0, req_ready_o}, 32'h0);
    chk("idle_alu_hold",  alu_src1_o, last_s1);
    chk("idle_op_hold",   {28'b0, alu_op_o}, {28'b0, last_op});

    // Single request ADD 5+7
    set_req(0, OP_ADD, 32'd5, 32'd7);
    t_v = 2'b01;
    do_one(0, 1'b0, 1'b0);

    // Response backpressure on req0; req1 becomes valid meanwhile and is
    // granted the cycle after the response handshake
    set_req(0, OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
    set_req(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    t_v = 2'b01;
    do_one(5, 1'b0, 1'b1);

    // Signed vs unsigned compare via req1
    do_one(0, 1'b0, 1'b0);
    set_req(1, OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    t_v = 2'b10;
    do_one(0, 1'b0, 1'b0);

    // Wrong-port response ready is ignored
    set_req(1, OP_SRA, 32'h8000_0000, 32'hFFFF_FFE4);
    t_v = 2'b10;
    do_one(3, 1'b1, 1'b0);

    // Reset in EXEC: prio was pointing at req1, must come back to req0
    set_req(0, OP_OR, 32'h00F0_0000, 32'h0000_000F);
    t_v = 2'b01;
    do_one(0, 1'b0, 1'b0);
    set_req(0, OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
    set_req(1, OP_SLL, 32'h0000_0001, 32'h0000_0024);
    t_v = 2'b11;
    txn_then_reset(1);
    do_one(0, 1'b0, 1'b0);

    // Reset in RESP
    rand_req(0);
    t_v = 2'b11;
    txn_then_reset(2);
    do_one(0, 1'b0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!t_v[n] && ($urandom_range(0, 1) == 1)) begin
          rand_req(n);
          t_v[n] = 1'b1;
        end
      end
      if (t_v == 2'b00) begin
        int n;
        n = int'($urandom_range(0, 1));
        rand_req(n);
        t_v[n] = 1'b1;
      end
      do_one(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
